// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Bus-facing controller between the UART receiver datapath and the
//   memory-mapped peripheral bus. It qualifies received bytes, buffers them
//   in a small FIFO, keeps sticky framing/overrun flags, and exposes
//   DATA/STATUS/CTRL registers plus a level interrupt.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   rx_valid   1-cycle strobe: receiver finished a frame
//   rx_data    received byte, valid with rx_valid
//   rx_stop    sampled stop bit (0 = framing error), valid with rx_valid
//   bus_sel    register access this cycle
//   bus_we     1 = write, 0 = read
//   bus_addr   word index: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//   bus_wdata  write data
//   bus_rdata  registered read data (holds when there is no read)
//   irq        registered level interrupt
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_stop,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // Storage carries no reset so it maps onto plain RAM; emptiness is
  // defined purely by the pointers and count.
  logic [7:0]       mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             rx_en_reg, rx_en_next;
  logic             irq_en_reg, irq_en_next;
  logic             ovr_reg, ovr_next;
  logic             ferr_reg, ferr_next;
  logic [31:0]      rdata_next;
  logic             irq_next;

  logic rd_acc, wr_acc;
  logic data_rd, status_wr, ctrl_wr;
  logic not_empty, full;
  logic flush, rx_take, push, pop, ovr_set, ferr_set;
  logic [31:0] status_word;

  // ---------------------------------------------------------------------
  // Access decode and event qualification
  // ---------------------------------------------------------------------
  always_comb begin
    rd_acc    = bus_sel & ~bus_we;
    wr_acc    = bus_sel & bus_we;
    data_rd   = rd_acc & (bus_addr == ADDR_DATA);
    status_wr = wr_acc & (bus_addr == ADDR_STATUS);
    ctrl_wr   = wr_acc & (bus_addr == ADDR_CTRL);

    not_empty = (count_reg != '0);
    full      = (count_reg == CNT_W'(FIFO_DEPTH));

    // Disabling the receiver empties the FIFO; a strobe landing in that
    // same cycle is dropped rather than surviving the flush.
    flush     = ctrl_wr & rx_en_reg & ~bus_wdata[0];
    rx_take   = rx_valid & rx_en_reg & ~flush;

    pop       = data_rd & not_empty;
    ferr_set  = rx_take & ~rx_stop;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push      = rx_take & rx_stop & (~full | pop);
    ovr_set   = rx_take & rx_stop & full & ~pop;
  end

  // ---------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------
  always_comb begin
    wptr_next   = wptr_reg;
    rptr_next   = rptr_reg;
    count_next  = count_reg;
    rx_en_next  = rx_en_reg;
    irq_en_next = irq_en_reg;

    if (flush) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the wrap.
      if (push) wptr_next = wptr_reg + PTR_W'(1);
      if (pop)  rptr_next = rptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end

    if (ctrl_wr) begin
      rx_en_next  = bus_wdata[0];
      irq_en_next = bus_wdata[1];
    end

    // W1C clear first, then OR in the set so a coincident event wins.
    ovr_next  = (ovr_reg  & ~(status_wr & bus_wdata[2])) | ovr_set;
    ferr_next = (ferr_reg & ~(status_wr & bus_wdata[3])) | ferr_set;

    irq_next  = irq_en_next & ((count_next != '0) | ovr_next | ferr_next);
  end

  // STATUS reflects the state before this cycle's updates.
  always_comb begin
    status_word              = '0;
    status_word[0]           = not_empty;
    status_word[1]           = full;
    status_word[2]           = ovr_reg;
    status_word[3]           = ferr_reg;
    status_word[8 +: CNT_W]  = count_reg;
  end

  always_comb begin
    rdata_next = bus_rdata;
    if (rd_acc) begin
      case (bus_addr)
        ADDR_DATA:   rdata_next = pop ? {23'b0, 1'b1, mem[rptr_reg]} : 32'h0;
        ADDR_STATUS: rdata_next = status_word;
        ADDR_CTRL:   rdata_next = {30'b0, irq_en_reg, rx_en_reg};
        default:     rdata_next = 32'h0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      count_reg  <= '0;
      rx_en_reg  <= 1'b0;
      irq_en_reg <= 1'b0;
      ovr_reg    <= 1'b0;
      ferr_reg   <= 1'b0;
      bus_rdata  <= '0;
      irq        <= 1'b0;
    end else begin
      wptr_reg   <= wptr_next;
      rptr_reg   <= rptr_next;
      count_reg  <= count_next;
      rx_en_reg  <= rx_en_next;
      irq_en_reg <= irq_en_next;
      ovr_reg    <= ovr_next;
      ferr_reg   <= ferr_next;
      bus_rdata  <= rdata_next;
      irq        <= irq_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl. Register reads push their expected value into
// a scoreboard queue; a monitor pops and compares whenever the DUT presents
// registered read data one cycle after a read access.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_stop;
  logic        bus_sel;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic rd_d;

  uart_rx_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_stop   (rx_stop),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Marks cycles whose read data becomes visible after the next posedge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_d <= 1'b0;
    else        rd_d <= bus_sel & ~bus_we;
  end

  // Monitor: compare presented read data against the scoreboard head.
  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", bus_rdata, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, bus_rdata, e.val);
        $display("read %-14s got 0x%08h expected 0x%08h", e.name, bus_rdata, e.val);
      end
    end
  end

  task automatic drive(logic v, logic [7:0] d, logic s,
                       logic sel, logic we, logic [1:0] a, logic [31:0] wd);
    @(negedge clk);
    rx_valid  = v;
    rx_data   = d;
    rx_stop   = s;
    bus_sel   = sel;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic expect_rd(string name, logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] val, string name);
    expect_rd(name, val);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] wd);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, a, wd);
  endtask

  task automatic strobe(logic [7:0] d, logic s);
    drive(1'b1, d, s, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; rx_stop = 1'b1;
    bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 32'h0;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_rdata", bus_rdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Basic receive and read-out.
    wr(2'd2, 32'h3);
    strobe(8'h41, 1'b1);
    strobe(8'h42, 1'b1);
    rd(2'd1, 32'h0000_0201, "status_two");
    idle();
    chk("irq_two", {31'b0, irq}, 32'h1);
    rd(2'd0, 32'h141, "data_41");
    rd(2'd0, 32'h142, "data_42");
    rd(2'd0, 32'h000, "data_empty");
    idle();
    idle();
    chk("irq_drop", {31'b0, irq}, 32'h0);

    // Overrun: nine bytes into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) strobe(8'(i), 1'b1);
    rd(2'd1, 32'h0000_0807, "status_ovr");
    for (int i = 0; i < 8; i++) rd(2'd0, 32'h100 | i, $sformatf("data_ovr_%0d", i));
    rd(2'd1, 32'h0000_0004, "status_ovr_kept");
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h0000_0000, "status_ovr_clr");

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) strobe(8'h10 + 8'(i), 1'b1);
    expect_rd("data_full_pp", 32'h110);
    drive(1'b1, 8'h18, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
    rd(2'd1, 32'h0000_0803, "status_full_pp");
    for (int i = 1; i <= 8; i++) rd(2'd0, 32'h110 + i, $sformatf("data_pp_%0d", i));
    rd(2'd1, 32'h0000_0000, "status_drained");

    // Framing error, W1C clear, and set-beats-clear.
    strobe(8'h55, 1'b0);
    rd(2'd1, 32'h0000_0008, "status_ferr");
    idle();
    chk("irq_ferr", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h8);
    rd(2'd1, 32'h0000_0000, "status_ferr_clr");
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 2'd1, 32'h8);
    rd(2'd1, 32'h0000_0008, "status_set_wins");
    wr(2'd1, 32'h8);
    rd(2'd1, 32'h0000_0000, "status_clr2");

    // Push and pop together on an empty FIFO.
    expect_rd("data_empty_pp", 32'h0);
    drive(1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
    rd(2'd1, 32'h0000_0101, "status_one");
    rd(2'd0, 32'h166, "data_66");

    // Receiver disable: ignore strobes, flush keeps sticky flags.
    wr(2'd2, 32'h0);
    strobe(8'h11, 1'b1);
    rd(2'd1, 32'h0000_0000, "status_disabled");
    rd(2'd2, 32'h0000_0000, "ctrl_zero");
    wr(2'd2, 32'h1);
    strobe(8'h21, 1'b1);
    strobe(8'h22, 1'b1);
    strobe(8'h23, 1'b1);
    strobe(8'h5A, 1'b0);
    rd(2'd1, 32'h0000_0309, "status_three");
    idle();
    chk("irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h0);
    rd(2'd1, 32'h0000_0008, "status_flushed");
    rd(2'd0, 32'h0, "data_flushed");
    wr(2'd2, 32'h1);
    strobe(8'h31, 1'b1);
    drive(1'b1, 8'h32, 1'b1, 1'b1, 1'b1, 2'd2, 32'h0);
    wr(2'd2, 32'h1);
    rd(2'd1, 32'h0000_0008, "status_flush_rx");
    wr(2'd1, 32'h8);
    rd(2'd1, 32'h0000_0000, "status_clr3");
    rd(2'd2, 32'h0000_0001, "ctrl_one");

    // Asynchronous reset between clock edges.
    wr(2'd2, 32'h3);
    strobe(8'h77, 1'b1);
    strobe(8'h78, 1'b1);
    rd(2'd1, 32'h0000_0201, "status_pre_rst");
    idle();
    chk("irq_pre_rst", {31'b0, irq}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rdata", bus_rdata, 32'h0);
    chk("async_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(2'd1, 32'h0000_0000, "status_post_rst");
    rd(2'd2, 32'h0000_0000, "ctrl_post_rst");
    wr(2'd2, 32'h1);
    strobe(8'h99, 1'b1);
    rd(2'd0, 32'h199, "data_post_rst");
    repeat (3) idle();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Bus-facing controller that sits between the UART receiver datapath and the rv32i memory-mapped peripheral bus.
- Accepts completed bytes from the receiver as 1-cycle strobes and qualifies them by enable and stop bit.
- Buffers accepted bytes in a FIFO and exposes data/status/control registers plus a level interrupt.
- Tracks framing and overrun errors as sticky flags that software clears.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries; power of two, >= 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy count (derived, not overridden)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
rx_valid  input  1  1-cycle strobe: receiver finished a frame
rx_data  input  8  received byte, valid with rx_valid
rx_stop  input  1  sampled stop bit, valid with rx_valid; 0 = framing error
bus_sel  input  1  register access this cycle
bus_we  input  1  1 = write, 0 = read
bus_addr  input  2  word index: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
bus_wdata  input  32  write data
bus_rdata  output  32  read data, registered
irq  output  1  level interrupt, registered

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, count 0, sticky flags 0, CTRL 0 (rx disabled), bus_rdata 0, irq 0.
- rx_valid handling:
  - Ignored completely (no flags set) when CTRL.rx_en = 0.
  - rx_stop = 0: byte discarded, STATUS.ferr set.
  - rx_stop = 1 and FIFO full, with no pop in the same cycle: byte dropped, STATUS.ovr set, FIFO contents unchanged.
  - Otherwise the byte is pushed at wptr, wptr wraps mod FIFO_DEPTH, and count increments.
- DATA read (bus_sel & !bus_we & addr 0):
  - Next cycle bus_rdata = {23'b0, 1'b1, head byte} and the entry is popped.
  - If empty: bus_rdata = 0, no pointer change, no error.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the pop frees the slot, so the push is accepted with no overrun.
  - When empty, the pop returns 0 and the push is accepted.
- STATUS read: bits [0] not_empty, [1] full, [2] ovr, [3] ferr, [8+CNT_W-1:8] count; all other bits 0. Value reflects pre-update state of the access cycle.
- STATUS write: a 1 in bit 2 or 3 clears that sticky flag (W1C); other bits ignored. If a set event and a clear hit the same flag in the same cycle, set wins.
- CTRL (read/write): bit0 rx_en, bit1 irq_en; other bits read 0.
  - Writing rx_en 1->0 flushes the FIFO (pointers and count to 0). Sticky flags are kept.
  - A byte arriving in the flush cycle is ignored.
- DATA write and any reserved-address access: no effect; reads return 0.
- bus_rdata: updated one cycle after any read. Holds its previous value on cycles with no read access.
- irq, registered: irq_en & (not_empty | ovr | ferr), computed from post-update state, so it asserts 1 cycle after the triggering push or flag set.
- No backpressure to the receiver; every strobe is resolved in its own cycle.
- rst_n asserted mid-frame or mid-access clears all state immediately. The first strobe after release is handled normally if rx_en has been set.

Test Plan:
- Reset, write CTRL=0x3, strobe rx_data 0x41, 0x42 with rx_stop=1 -> STATUS count=2, not_empty=1, irq=1; DATA reads return 0x141 then 0x142; a third read returns 0x000 and irq drops.
- rx_en=1, push 9 bytes 0x00..0x08 without reads -> count=8, full=1, ovr=1; reads return 0x100..0x107 (byte 0x08 lost).
- With FIFO full, rx_valid strobe in the same cycle as a DATA read -> read returns the oldest byte, new byte accepted, ovr stays 0, count stays 8.
- rx_valid with rx_stop=0, data 0x55 -> FIFO unchanged, ferr=1; write STATUS=0x8 -> ferr=0; a ferr event in the same cycle as the clear leaves ferr=1.
- rx_en=0, strobe 0x11 -> no push and no flags; rx_en=1, push 3 bytes, write CTRL=0x0 -> count=0, ovr/ferr unchanged.
- Push 2 bytes, assert rst_n=0 asynchronously between clock edges -> outputs 0 immediately; after release STATUS reads 0 and CTRL reads 0.
